pipeline_ctrl: RTL

//  Sequences the 5-stage pipeline: drives enable/flush of the PC and IF/ID latch, bubble into ID/EX,
//  and enable of the later latches. Implements run / single-step / halt-drain control for the debug

---
 rtl/pipeline_ctrl_pkg.sv | 19 +
 rtl/pipeline_ctrl_hazard_detect.sv | 26 ++
 rtl/pipeline_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
//   - state encoding of the run/step/drain controller
//   - NOP instruction word loaded into ID/EX when a bubble is inserted
package pipeline_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    // All-zero word decodes as sll $0,$0,0 and is used by the ID/EX bubble mux.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard comparator.
// Flags when the instruction in EX is a load whose destination register is
// read by the instruction currently in ID. Register 0 never creates a hazard.
// Ports:
//   i_id_ex_mem_read  load in EX
//   i_id_ex_rt        load destination in EX
//   i_if_id_rs        rs of instruction in ID
//   i_if_id_rt        rt of instruction in ID
//   o_load_use        hazard detected (combinational)
module hazard_detect #(
    parameter int SIZE_REG_ADDR = 5
) (
    input  logic                     i_id_ex_mem_read,
    input  logic [SIZE_REG_ADDR-1:0] i_id_ex_rt,
    input  logic [SIZE_REG_ADDR-1:0] i_if_id_rs,
    input  logic [SIZE_REG_ADDR-1:0] i_if_id_rt,
    output logic                     o_load_use
);

    always_comb begin
        o_load_use = i_id_ex_mem_read
                   && (i_id_ex_rt != '0)
                   && ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the 5-stage core.
// Drives PC / IF-ID enable and flush, ID-EX bubble and the back-end latch
// enable. Provides run, single-step and halt-drain control for the debug
// unit, plus load-use stall and taken-branch flush.
// Ports:
//   i_clk, i_reset      clock (rising edge), async active-high reset
//   i_run, i_step       debug start commands, honoured in IDLE only
//   i_clear             HALTED -> IDLE, clears the cycle counter
//   i_halt_id           HALT decoded in ID
//   i_id_ex_mem_read, i_id_ex_rt, i_if_id_rs, i_if_id_rt   load-use inputs
//   i_branch_taken      branch/jump resolved taken in EX
//   o_pc_enable, o_if_id_enable, o_if_id_flush, o_id_ex_bubble, o_pipe_enable
//                       combinational latch controls
//   o_halted            1 while in HALTED
//   o_cycle_count       saturating count of cycles with o_pipe_enable=1
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int SIZE_REG_ADDR  = 5,
    parameter int DRAIN_CYCLES   = 4,
    parameter int SIZE_CYCLE_CNT = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_run,
    input  logic                      i_step,
    input  logic                      i_clear,
    input  logic                      i_halt_id,
    input  logic                      i_id_ex_mem_read,
    input  logic [SIZE_REG_ADDR-1:0]  i_id_ex_rt,
    input  logic [SIZE_REG_ADDR-1:0]  i_if_id_rs,
    input  logic [SIZE_REG_ADDR-1:0]  i_if_id_rt,
    input  logic                      i_branch_taken,
    output logic                      o_pc_enable,
    output logic                      o_if_id_enable,
    output logic                      o_if_id_flush,
    output logic                      o_id_ex_bubble,
    output logic                      o_pipe_enable,
    output logic                      o_halted,
    output logic [SIZE_CYCLE_CNT-1:0] o_cycle_count
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    state_e                    state_q, state_d;
    logic [DRAIN_W-1:0]        drain_cnt_q, drain_cnt_d;
    logic [SIZE_CYCLE_CNT-1:0] cycle_cnt_q, cycle_cnt_d;
    logic                      load_use;

    function automatic logic [SIZE_CYCLE_CNT-1:0] sat_inc(input logic [SIZE_CYCLE_CNT-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 1'b1;
        end
    endfunction

    hazard_detect #(
        .SIZE_REG_ADDR (SIZE_REG_ADDR)
    ) u_hazard_detect (
        .i_id_ex_mem_read (i_id_ex_mem_read),
        .i_id_ex_rt       (i_id_ex_rt),
        .i_if_id_rs       (i_if_id_rs),
        .i_if_id_rt       (i_if_id_rt),
        .o_load_use       (load_use)
    );

    always_comb begin
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;
        cycle_cnt_d    = cycle_cnt_q;
        o_pc_enable    = 1'b0;
        o_if_id_enable = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b0;
        o_pipe_enable  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_run) begin
                    state_d = ST_RUN;
                end else if (i_step) begin
                    state_d = ST_STEP;
                end
            end

            ST_RUN, ST_STEP: begin
                o_pipe_enable = 1'b1;
                if (i_branch_taken) begin
                    // Flush wins over a stall: the stalled instruction is wrong-path.
                    o_pc_enable    = 1'b1;
                    o_if_id_enable = 1'b1;
                    o_if_id_flush  = 1'b1;
                    o_id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    o_id_ex_bubble = 1'b1;
                end else begin
                    o_pc_enable    = 1'b1;
                    o_if_id_enable = 1'b1;
                end

                // A HALT seen alongside a taken branch is on the wrong path.
                if (i_halt_id && !i_branch_taken) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else if (state_q == ST_STEP) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                // Front end frozen; the back end retires what is already in flight.
                o_id_ex_bubble = 1'b1;
                o_pipe_enable  = 1'b1;
                if (drain_cnt_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end

            ST_HALTED: begin
                if (i_clear) begin
                    state_d     = ST_IDLE;
                    drain_cnt_d = '0;
                    cycle_cnt_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (o_pipe_enable) begin
            cycle_cnt_d = sat_inc(cycle_cnt_q);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign o_halted      = (state_q == ST_HALTED);
    assign o_cycle_count = cycle_cnt_q;

endmodule
